// File: rtl/multi_byte_add_sequencer_pkg.sv
// Shared types and helpers for the multi-byte add sequencer.
// Holds the byte width, FSM state encoding and a byte-slice helper.
package add_seq_pkg;

    localparam int BYTE_W     = 8;
    localparam int MAX_WORD_W = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A shift is used rather than an indexed part-select so the index width never matters.
    function automatic logic [BYTE_W-1:0] byte_sel(input logic [MAX_WORD_W-1:0] word,
                                                   input int unsigned idx);
        logic [MAX_WORD_W-1:0] shifted;
        shifted = word >> (BYTE_W * idx);
        return shifted[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/multi_byte_add_sequencer.sv
// Feeds an external 8-bit adder one byte per clock, LSB first, and chains the carry between bytes.
// Optional signed-overflow flag is built only when ADD_SEQ_OVERFLOW_EN is defined.
//  state | meaning
//  IDLE  | waiting for start; adder inputs driven 0
//  RUN   | one byte added per edge, index selects the byte
//  DONE  | result valid for one cycle; start accepted back-to-back
module multi_byte_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [BYTE_W*NUM_BYTES-1:0] op_a,
    input  logic [BYTE_W*NUM_BYTES-1:0] op_b,
    input  logic                        cin_in,
    output logic [BYTE_W-1:0]           add_a,
    output logic [BYTE_W-1:0]           add_b,
    output logic                        add_cin,
    input  logic [BYTE_W-1:0]           add_s,
    input  logic                        add_cout,
    output logic                        busy,
    output logic                        done,
    output logic [BYTE_W*NUM_BYTES-1:0] result,
    output logic                        cout_out,
    output logic                        ovf
);

    localparam int WORD_W = BYTE_W * NUM_BYTES;
    localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t             state;
    logic [IDX_W-1:0]   index;
    logic               carry;
    logic [WORD_W-1:0]  cap_a;
    logic [WORD_W-1:0]  cap_b;
    logic               accept;
    logic               last_edge;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_edge = (state == RUN) && (index == LAST_IDX);

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = byte_sel(MAX_WORD_W'(cap_a), 32'(index));
            add_b   = byte_sel(MAX_WORD_W'(cap_b), 32'(index));
            add_cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            index    <= '0;
            carry    <= 1'b0;
            cap_a    <= '0;
            cap_b    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout_out <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        cap_a    <= op_a;
                        cap_b    <= op_b;
                        carry    <= cin_in;
                        index    <= '0;
                        result   <= '0;
                        cout_out <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (index == IDX_W'(i)) begin
                            result[BYTE_W*i +: BYTE_W] <= add_s;
                        end
                    end
                    carry <= add_cout;
                    if (last_edge) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cout_out <= add_cout;
                        index    <= '0;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    index <= '0;
                end
            endcase
        end
    end

`ifdef ADD_SEQ_OVERFLOW_EN
    logic ovf_r;

    // Signed overflow: operands agree in sign but the top sum byte disagrees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (accept) begin
            ovf_r <= 1'b0;
        end else if (last_edge) begin
            ovf_r <= (cap_a[WORD_W-1] == cap_b[WORD_W-1]) && (add_s[BYTE_W-1] != cap_a[WORD_W-1]);
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_multi_byte_add_sequencer.sv
// Self-checking bench for multi_byte_add_sequencer with a behavioural 8-bit adder beside it.
// Expected values come from whole-word arithmetic on the operands.
module tb_multi_byte_add_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin_in;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_s;
    logic         add_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout_out;
    logic         ovf;

    int tests = 0;
    int fails = 0;

    multi_byte_add_sequencer #(.NUM_BYTES(NB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin_in   (cin_in),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout_out (cout_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // External 8-bit adder
    always_comb begin
        {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s);
`ifdef ADD_SEQ_OVERFLOW_EN
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`else
        return 1'b0;
`endif
    endfunction

    // Called at the negedge following the accept edge; returns edges counted until done is seen.
    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
    endtask

    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input string tag);
        logic [W:0] sum;
        int         lat;
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        @(negedge clk);
        op_a = a; op_b = b; cin_in = cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_clr"}, result, 0);
        wait_done(0, lat);
        check({tag, "_lat"}, lat, NB);
        check({tag, "_res"}, result, sum[W-1:0]);
        check({tag, "_cout"}, cout_out, sum[W]);
        check({tag, "_ovf"}, ovf, exp_ovf(a, b, sum[W-1:0]));
        @(negedge clk);
        check({tag, "_pulse"}, {busy, done}, 0);
        check({tag, "_hold"}, result, sum[W-1:0]);
    endtask

    initial begin
        int         lat;
        logic       seen;
        logic [W:0] sum;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", {busy, done, cout_out, ovf}, 0);
        check("rst_result", result, 0);
        check("rst_adder", {add_a, add_b, add_cin}, 0);
        rst_n = 1'b1;

        run_add(32'h000000FF, 32'h00000001, 1'b0, "t1");
        check("t1_const", {cout_out, result}, {1'b0, 32'h00000100});
        run_add(32'hFFFFFFFF, 32'h00000001, 1'b0, "t2");
        check("t2_const", {cout_out, result}, {1'b1, 32'h00000000});
        run_add(32'h12345678, 32'h11111111, 1'b1, "t3");
        check("t3_const", {cout_out, result}, {1'b0, 32'h2345678A});

        // start during RUN with other operands must be ignored
        @(negedge clk);
        op_a = 32'hA5A5A5A5; op_b = 32'h5A5A5A5A; cin_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        op_a = 32'h01010101; op_b = 32'h02020202; cin_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat);
        check("t4_lat", lat, NB);
        check("t4_res", {cout_out, result}, {1'b1, 32'h00000000});
        @(negedge clk);
        check("t4_idle", busy, 0);

        // reset mid-RUN aborts with no DONE
        op_a = 32'h11223344; op_b = 32'h55667788; cin_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_rst_flags", {busy, done, cout_out, ovf}, 0);
        check("t4_rst_result", result, 0);
        check("t4_rst_adder", {add_a, add_b, add_cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("t4_rst_nodone", seen, 0);

        // start held high through DONE: back-to-back adds
        op_a = 32'hDEADBEEF; op_b = 32'h0BADF00D; cin_in = 1'b1; start = 1'b1;
        sum = {1'b0, op_a} + {1'b0, op_b} + 33'd1;
        @(negedge clk);
        wait_done(0, lat);
        check("t5_lat1", lat, NB);
        check("t5_res1", {cout_out, result}, sum);
        op_a = 32'h80000000; op_b = 32'h80000000; cin_in = 1'b0;
        sum = {1'b0, op_a} + {1'b0, op_b};
        @(negedge clk);
        check("t5_restart", {busy, done}, 2'b10);
        wait_done(0, lat);
        start = 1'b0;
        check("t5_lat2", lat, NB);
        check("t5_res2", {cout_out, result}, sum);
        check("t5_ovf2", ovf, exp_ovf(op_a, op_b, sum[W-1:0]));

        run_add(32'h7FFFFFFF, 32'h00000001, 1'b0, "t6");
        check("t6_const", result, 32'h80000000);
`ifdef ADD_SEQ_OVERFLOW_EN
        check("t6_ovf_const", ovf, 1);
`else
        check("t6_ovf_const", ovf, 0);
`endif

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_add(ra, rb, 1'($urandom_range(1)), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
